diff_amp_trim_ctrl: RTL and testbench

// - Digital offset-trim controller for NCH differential-amplifier channels on the analog tile.
// - Runs a per-channel SAR search on a TRIM_W-bit trim DAC code.
// - During the search it shorts the amp inputs (cal_short) and reads a comparator on the amp output.
// - Holds the trim codes afterwards; manual code load is available for characterisation.
// - Sits between the digital pins (ui_in/uo_out/uio) and the analog amp bank.

---
 rtl/diff_amp_pkg.sv | 32 +++
 rtl/diff_amp_sync2.sv | 30 +++
 rtl/diff_amp_trim_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_diff_amp_trim_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_amp_pkg.sv
// Shared definitions for the differential-amplifier offset-trim controller.
// Holds the calibration FSM state type and small constant helpers that
// derive the mid-scale code, the all-ones code and the channel index
// width from the block parameters.
package diff_amp_pkg;

    // Calibration sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT_CH,
        ST_FIN
    } calState_e;

    // Channel index width; a single channel still needs a 1-bit index
    function automatic int chWidth(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Mid-scale trim code (MSB only), the SAR starting point
    function automatic logic [7:0] midCode(input int trimW);
        return 8'(1) << (trimW - 1);
    endfunction

    // Full-scale trim code, used for saturation detection
    function automatic logic [7:0] allOnesCode(input int trimW);
        return 8'((1 << trimW) - 1);
    endfunction

endpackage

// File: rtl/diff_amp_sync2.sv
// Two-flop synchroniser for the asynchronous comparator output.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, clears both stages to 0
//   d_i   - asynchronous input
//   q_o   - synchronised output, two clk cycles behind d_i
module diff_amp_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/diff_amp_trim_ctrl.sv
// Offset-trim controller for a bank of differential amplifiers.
// Runs a per-channel successive-approximation search on the trim DAC code
// while the amp inputs are shorted, reading a comparator on the amp output.
// Trim codes are held afterwards and may be loaded manually when idle.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   ena               - block enable; low aborts a calibration, blocks start
//   start             - level-sampled calibration request (idle, auto mode)
//   abort             - cancel calibration in progress
//   man_mode          - enables manual code loads, disables auto start
//   man_we/ch/code    - manual write strobe, target channel, code
//   comp_in           - asynchronous comparator, 1 = amp output above ref
//   ch_sel            - channel routed to the comparator
//   cal_short         - short the inputs of channel ch_sel
//   trim              - packed codes, channel k at [k*TRIM_W +: TRIM_W]
//   sat               - channel finished at code 0 or full scale
//   busy              - calibration in progress
//   done              - sticky, last calibration completed without abort
module diff_amp_trim_ctrl
    import diff_amp_pkg::*;
#(
    parameter  int NCH        = 4,
    parameter  int TRIM_W     = 5,
    parameter  int SETTLE_CYC = 16,
    localparam int CH_W       = chWidth(NCH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    man_mode,
    input  logic                    man_we,
    input  logic [CH_W-1:0]         man_ch,
    input  logic [TRIM_W-1:0]       man_code,
    input  logic                    comp_in,
    output logic [CH_W-1:0]         ch_sel,
    output logic                    cal_short,
    output logic [NCH*TRIM_W-1:0]   trim,
    output logic [NCH-1:0]          sat,
    output logic                    busy,
    output logic                    done
);

    localparam int BIT_W = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;
    localparam int CNT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TRIM_W-1:0] MID      = TRIM_W'(midCode(TRIM_W));
    localparam logic [TRIM_W-1:0] ALL_ONES = TRIM_W'(allOnesCode(TRIM_W));
    localparam logic [BIT_W-1:0]  TOP_BIT  = BIT_W'(TRIM_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NCH - 1);

    calState_e                     state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [CH_W-1:0]               chSel_q, chSel_d;
    logic [BIT_W-1:0]              bitIdx_q, bitIdx_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [TRIM_W-1:0]             shadow_q, shadow_d;
    logic [NCH-1:0][TRIM_W-1:0]    trim_q, trim_d;
    logic [NCH-1:0]                sat_q, sat_d;
    logic                          calShort_q, calShort_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic compS;
    logic abortReq;
    logic manChValid;

    diff_amp_sync2 u_compSync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (comp_in),
        .q_o   (compS)
    );

    assign abortReq   = abort | ~ena;
    assign manChValid = (int'(man_ch) < NCH);

    // State and datapath registers; every trim code resets to mid-scale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            chSel_q    <= '0;
            bitIdx_q   <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            trim_q     <= {NCH{MID}};
            sat_q      <= '0;
            calShort_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            chSel_q    <= chSel_d;
            bitIdx_q   <= bitIdx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            trim_q     <= trim_d;
            sat_q      <= sat_d;
            calShort_q <= calShort_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: the case statement runs the SAR sequence, and the
    // abort block afterwards overrides anything it decided this cycle
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        chSel_d    = chSel_q;
        bitIdx_d   = bitIdx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        trim_d     = trim_q;
        sat_d      = sat_q;
        calShort_d = calShort_q;
        busy_d     = busy_q;
        done_d     = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start && ena && !man_mode) begin
                    state_d = ST_SETUP;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    sat_d   = '0;
                end else if (man_we && man_mode && manChValid) begin
                    trim_d[man_ch] = man_code;
                    sat_d[man_ch]  = 1'b0;
                end
            end
            ST_SETUP: begin
                chSel_d        = ch_q;
                calShort_d     = 1'b1;
                bitIdx_d       = TOP_BIT;
                cnt_d          = '0;
                shadow_d       = trim_q[ch_q];
                trim_d[ch_q]   = MID;
                state_d        = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                // Comparator high means the code overshoots: drop the trial bit
                if (compS) begin
                    trim_d[ch_q][bitIdx_q] = 1'b0;
                end
                if (bitIdx_q != '0) begin
                    trim_d[ch_q][bitIdx_q - 1'b1] = 1'b1;
                    bitIdx_d = bitIdx_q - 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    state_d = ST_NEXT_CH;
                end
            end
            ST_NEXT_CH: begin
                sat_d[ch_q] = (trim_q[ch_q] == '0) || (trim_q[ch_q] == ALL_ONES);
                if (ch_q == LAST_CH) begin
                    state_d = ST_FIN;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_FIN: begin
                calShort_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // In SETUP the shadow is not yet captured and the code is untouched,
        // so only later states need the code restored
        if (state_q != ST_IDLE && abortReq) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            calShort_d = 1'b0;
            done_d     = 1'b0;
            sat_d      = sat_q;
            trim_d     = trim_q;
            if (state_q != ST_SETUP) begin
                trim_d[ch_q] = shadow_q;
            end
        end
    end

    assign ch_sel    = chSel_q;
    assign cal_short = calShort_q;
    assign trim      = trim_q;
    assign sat       = sat_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_diff_amp_trim_ctrl.sv
// Self-checking bench for diff_amp_trim_ctrl: a default-parameter instance
// plus a minimal NCH=1/TRIM_W=2/SETTLE_CYC=3 instance sharing the clock.
module tb_diff_amp_trim_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, start, abort, manMode, manWe;
    logic [1:0]  manCh;
    logic [4:0]  manCode;
    logic        compIn;
    logic [1:0]  chSel;
    logic        calShort;
    logic [19:0] trimOut;
    logic [3:0]  sat;
    logic        busy, done;

    logic        startS, manModeS, manWeS, manChS, compInS;
    logic [1:0]  manCodeS;
    logic        chSelS, calShortS, satS, busyS, doneS;
    logic [1:0]  trimS;

    logic [4:0]  target [4];
    logic [4:0]  model  [4];
    logic [1:0]  targetS;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    diff_amp_trim_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .man_mode(manMode), .man_we(manWe), .man_ch(manCh), .man_code(manCode),
        .comp_in(compIn), .ch_sel(chSel), .cal_short(calShort), .trim(trimOut),
        .sat(sat), .busy(busy), .done(done)
    );

    diff_amp_trim_ctrl #(.NCH(1), .TRIM_W(2), .SETTLE_CYC(3)) dutSmall (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .start(startS), .abort(1'b0),
        .man_mode(manModeS), .man_we(manWeS), .man_ch(manChS), .man_code(manCodeS),
        .comp_in(compInS), .ch_sel(chSelS), .cal_short(calShortS), .trim(trimS),
        .sat(satS), .busy(busyS), .done(doneS)
    );

    // Comparator model: amp output above reference when code exceeds target
    assign compIn  = (trimOut[chSel*5 +: 5] > target[chSel]);
    assign compInS = (trimS > targetS);

    typedef struct {
        logic        mode;
        logic [1:0]  ch;
        logic [4:0]  code;
        logic [19:0] expTrim;
        logic [3:0]  expSat;
    } manVec_t;

    manVec_t manTable [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] packModel();
        logic [19:0] p;
        for (int k = 0; k < 4; k++) p[k*5 +: 5] = model[k];
        return p;
    endfunction

    // Best SAR outcome: the largest code whose comparator reading stays low
    function automatic logic [4:0] sarResult(input logic [4:0] t);
        logic [4:0] best = 5'd0;
        for (int c = 0; c < 32; c++) if (c <= int'(t)) best = 5'(c);
        return best;
    endfunction

    function automatic logic [3:0] satModel();
        logic [3:0] s;
        for (int k = 0; k < 4; k++) s[k] = (model[k] == 5'd0) || (model[k] == 5'd31);
        return s;
    endfunction

    task automatic applyStimulus(input manVec_t v);
        @(negedge clk);
        manMode = v.mode; manWe = 1'b1; manCh = v.ch; manCode = v.code;
        @(negedge clk);
        manWe = 1'b0; manMode = 1'b0;
    endtask

    task automatic startCal();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Returns edges from the accepting edge (counted as 1) until done is seen
    task automatic runCal(input bit disturb, output int lat);
        startCal();
        lat = 1;
        while (done !== 1'b1 && lat < 1000) begin
            if (disturb && lat == 100) begin
                start = 1'b1; manMode = 1'b1; manWe = 1'b1; manCh = 2'd0; manCode = 5'd1;
            end
            @(negedge clk); lat++;
            if (disturb && lat == 101) begin
                start = 1'b0; manMode = 1'b0; manWe = 1'b0;
                checkOutput("busyMidCal", 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic runCalSmall(output int lat);
        @(negedge clk); startS = 1'b1;
        @(negedge clk); startS = 1'b0;
        lat = 1;
        while (doneS !== 1'b1 && lat < 200) begin
            @(negedge clk); lat++;
        end
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
        manMode = 1'b0; manWe = 1'b0; manCh = '0; manCode = '0;
        startS = 1'b0; manModeS = 1'b0; manWeS = 1'b0; manChS = 1'b0; manCodeS = '0;
        for (int k = 0; k < 4; k++) begin target[k] = 5'd0; model[k] = 5'd16; end
        targetS = 2'd0;

        manTable[0] = '{1'b1, 2'd3, 5'd9,  {5'd9, 5'd31, 5'd0,  5'd13}, 4'b0110};
        manTable[1] = '{1'b0, 2'd0, 5'd1,  {5'd9, 5'd31, 5'd0,  5'd13}, 4'b0110};
        manTable[2] = '{1'b1, 2'd0, 5'd31, {5'd9, 5'd31, 5'd0,  5'd31}, 4'b0110};
        manTable[3] = '{1'b1, 2'd1, 5'd22, {5'd9, 5'd31, 5'd22, 5'd31}, 4'b0100};
        manTable[4] = '{1'b1, 2'd2, 5'd4,  {5'd9, 5'd4,  5'd22, 5'd31}, 4'b0000};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstTrim", 32'(trimOut), 32'(packModel()));
        checkOutput("rstSat", 32'(sat), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstShort", 32'(calShort), 32'd0);
        checkOutput("rstChSel", 32'(chSel), 32'd0);

        // Full calibration with fixed targets
        target = '{5'd13, 5'd0, 5'd31, 5'd7};
        for (int k = 0; k < 4; k++) model[k] = sarResult(target[k]);
        runCal(1'b0, lat);
        checkOutput("fixedLatency", 32'(lat), 32'd350);
        checkOutput("fixedTrim", 32'(trimOut), 32'(packModel()));
        checkOutput("fixedSat", 32'(sat), 32'(satModel()));
        checkOutput("fixedDone", 32'(done), 32'd1);
        checkOutput("fixedBusy", 32'(busy), 32'd0);
        checkOutput("fixedShort", 32'(calShort), 32'd0);
        checkOutput("fixedChSel", 32'(chSel), 32'd3);

        // Manual load table
        for (int i = 0; i < 5; i++) begin
            applyStimulus(manTable[i]);
            checkOutput($sformatf("manTrim%0d", i), 32'(trimOut), 32'(manTable[i].expTrim));
            checkOutput($sformatf("manSat%0d", i), 32'(sat), 32'(manTable[i].expSat));
        end
        model = '{5'd31, 5'd22, 5'd4, 5'd9};

        // Abort during channel 2, bit 3 settle
        target = '{5'd20, 5'd5, 5'd3, 5'd0};
        startCal();
        repeat (194) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        model[0] = sarResult(5'd20);
        model[1] = sarResult(5'd5);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortShort", 32'(calShort), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortTrim", 32'(trimOut), 32'(packModel()));
        repeat (3) @(negedge clk);
        checkOutput("abortStaysIdle", 32'(busy), 32'd0);

        // ena dropped during channel 0 settle
        startCal();
        repeat (4) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        checkOutput("enaBusy", 32'(busy), 32'd0);
        checkOutput("enaShort", 32'(calShort), 32'd0);
        checkOutput("enaDone", 32'(done), 32'd0);
        checkOutput("enaTrim", 32'(trimOut), 32'(packModel()));

        // Randomized calibrations; the first also pokes start/man_we mid-run
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                target[k] = 5'($urandom_range(0, 31));
                model[k]  = sarResult(target[k]);
            end
            runCal(r == 0, lat);
            checkOutput($sformatf("rndLatency%0d", r), 32'(lat), 32'd350);
            checkOutput($sformatf("rndTrim%0d", r), 32'(trimOut), 32'(packModel()));
            checkOutput($sformatf("rndSat%0d", r), 32'(sat), 32'(satModel()));
            checkOutput($sformatf("rndDone%0d", r), 32'(done), 32'd1);
        end

        // start ignored in manual mode
        @(negedge clk); manMode = 1'b1; start = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("manModeNoStart", 32'(busy), 32'd0);
        start = 1'b0; manMode = 1'b0;
        checkOutput("manModeTrim", 32'(trimOut), 32'(packModel()));

        // Asynchronous reset mid-cycle
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstTrim", 32'(trimOut), 32'({4{5'd16}}));
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        checkOutput("asyncRstDone", 32'(done), 32'd0);
        checkOutput("asyncRstShort", 32'(calShort), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Minimal instance: out-of-range manual write, then calibrations
        checkOutput("smallRstTrim", 32'(trimS), 32'd2);
        @(negedge clk); manModeS = 1'b1; manWeS = 1'b1; manChS = 1'b1; manCodeS = 2'd1;
        @(negedge clk); manWeS = 1'b0;
        checkOutput("smallBadCh", 32'(trimS), 32'd2);
        manWeS = 1'b1; manChS = 1'b0;
        @(negedge clk); manWeS = 1'b0; manModeS = 1'b0;
        checkOutput("smallManWrite", 32'(trimS), 32'd1);
        targetS = 2'd2;
        runCalSmall(lat);
        checkOutput("smallLatency", 32'(lat), 32'd12);
        checkOutput("smallTrim", 32'(trimS), 32'd2);
        checkOutput("smallSat", 32'(satS), 32'd0);
        targetS = 2'd3;
        runCalSmall(lat);
        checkOutput("smallLatency2", 32'(lat), 32'd12);
        checkOutput("smallTrim2", 32'(trimS), 32'd3);
        checkOutput("smallSat2", 32'(satS), 32'd1);
        checkOutput("smallDone2", 32'(doneS), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
